clock_display_scan: RTL and testbench

Display-side consumer of the clock/stopwatch time bus. It takes the binary seconds, minutes and hours values produced by the timekeeping block and drives a six-digit, common-anode, time-multiplexed seven-segment display. It takes a tear-free snapshot of the time bus once per display frame, converts each field to two BCD digits, and scans one digit per scan period. A mode indicator is carried on the separator decimal points.

---
 rtl/clock_display_scan_if.sv | 26 ++
 rtl/clock_display_scan.sv | 174 +++++++++++++++++
 tb/tb_clock_display_scan.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/clock_display_scan_if.sv
// clock_display_scan_if
// Bundles the time bus (s, m, h, mode, blank) feeding the display scanner
// together with the display drive it produces (an, seg, dp, frame).
//   master : drives the time bus, observes the display drive
//   slave  : the scanner; consumes the time bus, drives the display
interface clock_display_scan_if;
    logic [5:0] s;
    logic [5:0] m;
    logic [4:0] h;
    logic       mode;
    logic       blank;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame;

    modport master (
        output s, m, h, mode, blank,
        input  an, seg, dp, frame
    );

    modport slave (
        input  s, m, h, mode, blank,
        output an, seg, dp, frame
    );
endinterface

// File: rtl/clock_display_scan.sv
// clock_display_scan
// Six-digit common-anode multiplexed seven-segment driver for the time bus.
// Once per frame (6 * SCAN_DIV cycles) the s/m/h fields are snapshotted so a
// frame never mixes two different times; each field is split into two BCD
// digits and one digit is lit per scan period. The separator decimal points
// (digits 2 and 4) show steady in stopwatch mode and blink in clock mode.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - slave modport: s, m, h, mode, blank in; an, seg, dp, frame out
//          (an/seg/dp active-low, frame one-cycle pulse)
module clock_display_scan #(
    parameter int SCAN_DIV = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    clock_display_scan_if.slave  bus
);
    localparam int            PW       = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRE_MAX  = PW'(SCAN_DIV - 1);
    localparam logic [6:0]    SEG_DASH = 7'b0111111;
    localparam logic [6:0]    SEG_OFF  = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} pattern for one BCD digit.
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] c;
        case (d)
            4'd0:    c = 7'b1000000;
            4'd1:    c = 7'b1111001;
            4'd2:    c = 7'b0100100;
            4'd3:    c = 7'b0110000;
            4'd4:    c = 7'b0011001;
            4'd5:    c = 7'b0010010;
            4'd6:    c = 7'b0000010;
            4'd7:    c = 7'b1111000;
            4'd8:    c = 7'b0000000;
            4'd9:    c = 7'b0010000;
            default: c = SEG_OFF;
        endcase
        return c;
    endfunction

    logic [PW-1:0] pre_r;
    logic [2:0]    idx_r;
    logic [4:0]    fcnt_r;
    logic [5:0]    snap_s_r;
    logic [5:0]    snap_m_r;
    logic [4:0]    snap_h_r;
    logic          boundary_d_r;
    logic [5:0]    an_r;
    logic [6:0]    seg_r;
    logic          dp_r;
    logic          frame_r;

    logic          tick_s;
    logic          boundary_s;
    logic [5:0]    field_s;
    logic [5:0]    limit_s;
    logic [3:0]    tens_s;
    logic [3:0]    ones_s;
    logic [3:0]    digit_s;
    logic [5:0]    an_s;
    logic [6:0]    seg_s;
    logic          dp_s;

    // Scan period end and frame boundary detection.
    always_comb begin
        tick_s     = (pre_r == PRE_MAX);
        boundary_s = tick_s && (idx_r == 3'd5);
    end

    // Prescaler, digit index, frame counter and per-frame snapshot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_r        <= {PW{1'b0}};
            idx_r        <= 3'd0;
            fcnt_r       <= 5'd0;
            snap_s_r     <= 6'd0;
            snap_m_r     <= 6'd0;
            snap_h_r     <= 5'd0;
            boundary_d_r <= 1'b0;
        end else begin
            if (tick_s) begin
                pre_r <= {PW{1'b0}};
                idx_r <= (idx_r == 3'd5) ? 3'd0 : idx_r + 3'd1;
            end else begin
                pre_r <= pre_r + PW'(1);
            end
            if (boundary_s) begin
                snap_s_r <= bus.s;
                snap_m_r <= bus.m;
                snap_h_r <= bus.h;
                fcnt_r   <= fcnt_r + 5'd1;
            end
            boundary_d_r <= boundary_s;
        end
    end

    // Select the field for the current digit, split it into BCD, encode it.
    always_comb begin
        field_s = 6'd0;
        limit_s = 6'd59;
        case (idx_r)
            3'd0, 3'd1: begin
                field_s = snap_s_r;
                limit_s = 6'd59;
            end
            3'd2, 3'd3: begin
                field_s = snap_m_r;
                limit_s = 6'd59;
            end
            3'd4, 3'd5: begin
                field_s = {1'b0, snap_h_r};
                limit_s = 6'd23;
            end
            default: begin
                field_s = 6'd0;
                limit_s = 6'd59;
            end
        endcase
        tens_s = 4'(field_s / 6'd10);
        ones_s = 4'(field_s % 6'd10);
        // Odd index positions carry the tens digit.
        if (idx_r[0]) begin
            digit_s = tens_s;
        end else begin
            digit_s = ones_s;
        end
        // An out-of-range field shows dashes on both of its digits.
        if (field_s > limit_s) begin
            seg_s = SEG_DASH;
        end else begin
            seg_s = seg_code(digit_s);
        end
        an_s = ~(6'b000001 << idx_r);
        // Separator dots sit on the ones digits of minutes and hours.
        if ((idx_r == 3'd2) || (idx_r == 3'd4)) begin
            if (bus.mode) begin
                dp_s = ~fcnt_r[4];
            end else begin
                dp_s = 1'b0;
            end
        end else begin
            dp_s = 1'b1;
        end
    end

    // Registered display drive. frame is delayed one extra cycle so that it
    // coincides with digit 0 of the fresh snapshot appearing on an/seg.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an_r    <= 6'b111111;
            seg_r   <= SEG_OFF;
            dp_r    <= 1'b1;
            frame_r <= 1'b0;
        end else begin
            if (bus.blank) begin
                an_r  <= 6'b111111;
                seg_r <= SEG_OFF;
                dp_r  <= 1'b1;
            end else begin
                an_r  <= an_s;
                seg_r <= seg_s;
                dp_r  <= dp_s;
            end
            frame_r <= boundary_d_r;
        end
    end

    assign bus.an    = an_r;
    assign bus.seg   = seg_r;
    assign bus.dp    = dp_r;
    assign bus.frame = frame_r;
endmodule

// File: tb/tb_clock_display_scan.sv
// tb_clock_display_scan
// Randomised self-checking bench for clock_display_scan with SCAN_DIV = 4.
// The reference model tracks time as an edge count since reset release and
// derives digit position, frame number and displayed snapshot arithmetically.
module tb_clock_display_scan;
    localparam int SD    = 4;
    localparam int FRAME = 6 * SD;

    logic clk;
    logic rst;
    clock_display_scan_if bus ();

    clock_display_scan #(.SCAN_DIV(SD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [6:0] seg_table [10];

    // Model state: edges since release, frames loaded, displayed snapshot.
    int n;
    int frames;
    int ms, mm, mh;
    bit pend_frame;

    task automatic check_value(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_an"},    int'(bus.an),    32'h3F);
        check_value({tag, "_seg"},   int'(bus.seg),   32'h7F);
        check_value({tag, "_dp"},    int'(bus.dp),    1);
        check_value({tag, "_frame"}, int'(bus.frame), 0);
    endtask

    task automatic model_clear();
        n          = 0;
        frames     = 0;
        ms         = 0;
        mm         = 0;
        mh         = 0;
        pend_frame = 1'b0;
    endtask

    // Assert reset at a falling edge (asynchronously), hold, release.
    task automatic apply_reset(input int cyc);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_now");
        for (int i = 0; i < cyc; i++) begin
            @(negedge clk);
            check_reset_outputs("rst_hold");
        end
        rst = 1'b0;
        model_clear();
    endtask

    // One clock: predict, advance the model on the edge, compare at negedge.
    task automatic cycle_and_check();
        int idx, val, lim, dig;
        logic [5:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_frame;
        idx = (n / SD) % 6;
        val = (idx < 2) ? ms : ((idx < 4) ? mm : mh);
        lim = (idx < 4) ? 59 : 23;
        dig = (idx % 2 == 1) ? val / 10 : val % 10;
        e_seg = (val > lim) ? 7'b0111111 : seg_table[dig];
        e_an  = ~(6'b000001 << idx);
        if (idx == 2 || idx == 4)
            e_dp = bus.mode ? (((frames / 16) % 2) == 0) : 1'b0;
        else
            e_dp = 1'b1;
        if (bus.blank) begin
            e_an  = 6'b111111;
            e_seg = 7'b1111111;
            e_dp  = 1'b1;
        end
        e_frame = pend_frame;
        @(posedge clk);
        n++;
        pend_frame = ((n % FRAME) == 0);
        if ((n % FRAME) == 0) begin
            ms = int'(bus.s);
            mm = int'(bus.m);
            mh = int'(bus.h);
            frames++;
        end
        @(negedge clk);
        check_value("an",    int'(bus.an),    int'(e_an));
        check_value("seg",   int'(bus.seg),   int'(e_seg));
        check_value("dp",    int'(bus.dp),    int'(e_dp));
        check_value("frame", int'(bus.frame), int'(e_frame));
    endtask

    task automatic rand_time();
        bus.s = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 59));
        bus.m = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 59));
        bus.h = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 23));
    endtask

    // Run cycles; optionally perturb the time bus at random instants.
    task automatic run(input int cyc, input bit perturb);
        for (int i = 0; i < cyc; i++) begin
            cycle_and_check();
            if (perturb && $urandom_range(0, 9) == 0) rand_time();
        end
    endtask

    initial begin
        seg_table[0] = 7'b1000000; seg_table[1] = 7'b1111001;
        seg_table[2] = 7'b0100100; seg_table[3] = 7'b0110000;
        seg_table[4] = 7'b0011001; seg_table[5] = 7'b0010010;
        seg_table[6] = 7'b0000010; seg_table[7] = 7'b1111000;
        seg_table[8] = 7'b0000000; seg_table[9] = 7'b0010000;

        bus.s = 6'd37; bus.m = 6'd5; bus.h = 5'd12;
        bus.mode = 1'b0; bus.blank = 1'b0;
        rst = 1'b1;
        model_clear();

        // Reset held for three cycles, then scan order with a steady time.
        apply_reset(3);
        run(3 * FRAME, 1'b0);

        // Out-of-range seconds and hours, legal minutes.
        bus.s = 6'd60; bus.m = 6'd59; bus.h = 5'd24;
        run(2 * FRAME, 1'b0);

        // Snapshot hold: seconds change 8 cycles into a frame.
        @(negedge clk);
        apply_reset(1);
        bus.s = 6'd10; bus.m = 6'd0; bus.h = 5'd0;
        run(FRAME + 8, 1'b0);
        bus.s = 6'd11;
        run(2 * FRAME, 1'b0);

        // Blanking for 50 cycles while frames keep coming.
        bus.blank = 1'b1;
        run(50, 1'b1);
        bus.blank = 1'b0;
        run(FRAME, 1'b1);

        // Clock mode: run past 32 frames so the separator blink flips twice.
        bus.mode = 1'b1;
        run(35 * FRAME, 1'b1);

        // Reset in the middle of a frame at digit index 3.
        for (int i = 0; i < FRAME && ((n / SD) % 6) != 3; i++) cycle_and_check();
        check_value("mid_idx", (n / SD) % 6, 3);
        apply_reset(2);
        run(2 * FRAME, 1'b1);

        // Fully random tail with mode and blank toggling.
        for (int i = 0; i < 600; i++) begin
            cycle_and_check();
            if ($urandom_range(0, 9) == 0) rand_time();
            if ($urandom_range(0, 49) == 0) bus.mode = ~bus.mode;
            if ($urandom_range(0, 29) == 0) bus.blank = ~bus.blank;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
